// File: rtl/serial_subtractor_de2_if.sv
// Board-facing switch and LED bundle for the serial subtractor.
// The controller drives the LEDs; the board or testbench drives the switches.
interface serial_subtractor_de2_if;
    logic [17:0] SW;
    logic [7:0]  LEDR;
    logic [3:0]  LEDG;

    modport master (output SW, input LEDR, input LEDG);
    modport slave  (input SW, output LEDR, output LEDG);
endinterface

// File: rtl/serial_subtractor_de2.sv
// Bit-serial A - B, LSB first, one bit per clock, with a borrow chain.
// KEY[0] is a synchronous active-low reset; a press of KEY[1] starts an operation.
//
// state | meaning
// IDLE  | after reset, waiting for the first start
// SHIFT | one difference bit produced per cycle, WIDTH cycles total
// DONE  | result shown on LEDs, waiting for the next start
module serial_subtractor_de2 #(
    parameter int WIDTH = 8
) (
    input  logic                   CLOCK_50,
    input  logic [3:0]             KEY,
    serial_subtractor_de2_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t state_q, state_d;

    logic             rst_b;
    logic             key_s1, key_s2;
    logic [1:0]       sync_fill;
    logic             armed;
    logic             start;
    logic             load, shift_en, last_bit;
    logic [WIDTH-1:0] sh_a, sh_b, res, res_next;
    logic             msb_a, msb_b;
    logic             borrow, d_bit, bout;
    logic [3:0]       cnt;
    logic [WIDTH-1:0] led_d;
    logic             led_bout, led_ovf;
    logic             unused_inputs;

    assign rst_b         = KEY[0];
    assign unused_inputs = ^{KEY[3:2], bus.SW};

    // The synchronizer is forced high in reset, so a key held low through reset
    // would look like a fresh press; start is only armed once the real key is seen high.
    always_ff @(posedge CLOCK_50) begin
        if (!rst_b) begin
            key_s1    <= 1'b1;
            key_s2    <= 1'b1;
            sync_fill <= 2'd0;
            armed     <= 1'b0;
        end else begin
            key_s1 <= KEY[1];
            key_s2 <= key_s1;
            if (sync_fill != 2'd2)
                sync_fill <= sync_fill + 2'd1;
            if (start)
                armed <= 1'b0;
            else if (sync_fill == 2'd2 && key_s2)
                armed <= 1'b1;
        end
    end

    assign start    = armed & ~key_s2;
    assign last_bit = (cnt == 4'(WIDTH - 1));

    always_ff @(posedge CLOCK_50) begin
        if (!rst_b)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        shift_en = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (last_bit)
                    state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign d_bit    = sh_a[0] ^ sh_b[0] ^ borrow;
    assign bout     = (~sh_a[0] & sh_b[0]) | (~(sh_a[0] ^ sh_b[0]) & borrow);
    assign res_next = (res >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));

    always_ff @(posedge CLOCK_50) begin
        if (!rst_b) begin
            sh_a     <= '0;
            sh_b     <= '0;
            res      <= '0;
            msb_a    <= 1'b0;
            msb_b    <= 1'b0;
            borrow   <= 1'b0;
            cnt      <= 4'd0;
            led_d    <= '0;
            led_bout <= 1'b0;
            led_ovf  <= 1'b0;
        end else if (load) begin
            sh_a   <= bus.SW[WIDTH-1:0];
            sh_b   <= bus.SW[WIDTH+7:8];
            msb_a  <= bus.SW[WIDTH-1];
            msb_b  <= bus.SW[WIDTH+7];
            borrow <= 1'b0;
            cnt    <= 4'd0;
        end else if (shift_en) begin
            sh_a   <= sh_a >> 1;
            sh_b   <= sh_b >> 1;
            res    <= res_next;
            borrow <= bout;
            cnt    <= cnt + 4'd1;
            // Final d_bit is the result sign bit, so overflow needs no extra cycle.
            if (last_bit) begin
                led_d    <= res_next;
                led_bout <= bout;
                led_ovf  <= (msb_a != msb_b) && (d_bit != msb_a);
            end
        end
    end

    assign bus.LEDR = 8'(led_d);
    assign bus.LEDG = {led_ovf, state_q == DONE, state_q == SHIFT, led_bout};
endmodule

// File: tb/tb_serial_subtractor_de2.sv
// Scoreboard bench for serial_subtractor_de2: directed board scenarios plus random operands.
// Expected results come from plain integer arithmetic; a monitor checks each completion.
module tb_serial_subtractor_de2;
    localparam int WIDTH = 8;

    typedef struct {
        logic [7:0] d;
        logic       bo;
        logic       ov;
    } exp_t;

    logic       clk = 1'b0;
    logic [3:0] key;
    exp_t       sb_q[$];
    exp_t       mon_e;
    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_done  = 0;
    int         nd;
    logic [7:0] last_ledr = 8'h00;
    logic       done_prev = 1'b0;

    always #5 clk = ~clk;

    serial_subtractor_de2_if bus ();

    serial_subtractor_de2 #(.WIDTH(WIDTH)) dut (
        .CLOCK_50 (clk),
        .KEY      (key),
        .bus      (bus.slave)
    );

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int   sa, sb, diff;
        sa   = (a >= 8'd128) ? int'(a) - 256 : int'(a);
        sb   = (b >= 8'd128) ? int'(b) - 256 : int'(b);
        diff = sa - sb;
        e.d  = 8'(int'(a) - int'(b));
        e.bo = (a < b);
        e.ov = (diff > 127) || (diff < -128);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (bus.LEDG[2] && !done_prev) begin
            n_done++;
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got completion, expected none (t=%0t)", $time);
            end else begin
                mon_e = sb_q.pop_front();
                check("result_ledr", 32'(bus.LEDR), 32'(mon_e.d));
                check("result_borrow", 32'(bus.LEDG[0]), 32'(mon_e.bo));
                check("result_ovf", 32'(bus.LEDG[3]), 32'(mon_e.ov));
            end
        end
        done_prev = bus.LEDG[2];
    end

    task automatic release_key();
        @(negedge clk);
        key[1] = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_op(input logic [7:0] a, input logic [7:0] b);
        int busy_n;
        int edge_n;
        bit got;
        release_key();
        @(negedge clk);
        bus.SW[7:0]  = a;
        bus.SW[15:8] = b;
        key[1] = 1'b0;
        sb_q.push_back(model(a, b));
        busy_n = 0;
        edge_n = 0;
        got    = 1'b0;
        while (!got && edge_n < 40) begin
            @(posedge clk);
            #1;
            edge_n++;
            if (bus.LEDG[1]) busy_n++;
            if (edge_n == 4) bus.SW = 18'($urandom);
            if (edge_n == WIDTH + 2) check("ledr_hold", 32'(bus.LEDR), 32'(last_ledr));
            if (edge_n >= 3 && bus.LEDG[2]) got = 1'b1;
        end
        check("done_edge", got ? edge_n : 0, WIDTH + 3);
        check("busy_cycles", busy_n, WIDTH);
        last_ledr = model(a, b).d;
        @(negedge clk);
        key[1] = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        key    = 4'b1100;
        bus.SW = '0;
        repeat (4) @(posedge clk);
        #1;
        check("reset_ledr", 32'(bus.LEDR), 32'h00);
        check("reset_ledg", 32'(bus.LEDG), 32'h0);

        // Start key held low across reset must not start anything.
        @(negedge clk);
        key[0] = 1'b1;
        repeat (20) @(negedge clk);
        check("held_key_no_start", 32'(bus.LEDG), 32'h0);

        do_op(8'h05, 8'h03);
        do_op(8'h03, 8'h05);
        do_op(8'h00, 8'h00);
        do_op(8'h80, 8'h01);
        do_op(8'h7F, 8'hFF);

        // Re-press and switch changes during SHIFT are ignored.
        release_key();
        nd = n_done;
        @(negedge clk);
        bus.SW[7:0]  = 8'h05;
        bus.SW[15:8] = 8'h03;
        key[1] = 1'b0;
        sb_q.push_back(model(8'h05, 8'h03));
        repeat (4) @(negedge clk);
        key[1] = 1'b1;
        repeat (2) @(negedge clk);
        key[1] = 1'b0;
        bus.SW[7:0]  = 8'h10;
        bus.SW[15:8] = 8'h01;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.LEDG[2]) break;
        end
        check("done_after_repress", 32'(bus.LEDG[2]), 32'h1);
        repeat (10) @(negedge clk);
        check("single_completion", n_done - nd, 1);
        last_ledr = 8'h02;
        do_op(8'h10, 8'h01);

        // Reset on the 4th SHIFT cycle discards the partial result.
        release_key();
        nd = n_done;
        @(negedge clk);
        bus.SW[7:0]  = 8'h09;
        bus.SW[15:8] = 8'h04;
        key[1] = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        key[0] = 1'b0;
        key[1] = 1'b1;
        @(posedge clk);
        #1;
        check("abort_ledg", 32'(bus.LEDG), 32'h0);
        check("abort_ledr", 32'(bus.LEDR), 32'h00);
        @(negedge clk);
        key[0] = 1'b1;
        last_ledr = 8'h00;
        check("abort_no_done", n_done - nd, 0);
        do_op(8'h09, 8'h04);

        // Long press gives one operation and DONE persists.
        release_key();
        nd = n_done;
        @(negedge clk);
        bus.SW[7:0]  = 8'h33;
        bus.SW[15:8] = 8'h11;
        key[1] = 1'b0;
        sb_q.push_back(model(8'h33, 8'h11));
        repeat (100) @(negedge clk);
        check("hold_one_op", n_done - nd, 1);
        check("hold_done_persist", 32'(bus.LEDG[2]), 32'h1);
        last_ledr = 8'h22;
        do_op(8'h44, 8'h45);

        for (int i = 0; i < 20; i++)
            do_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_subtractor_de2.md
SERIAL_SUBTRACTOR_DE2 -- requirements
Module: SERIAL_SUBTRACTOR_DE2

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; legal range 1..8.
REQ-002 CLOCK_50  in  1  50 MHz system clock; all state SHALL change only on its rising edge.
REQ-003 KEY  in  4  DE2 pushbuttons, active-low; KEY[0] SHALL be the reset: synchronous, active-low. KEY[1] SHALL be start. KEY[3:2] SHALL be unused.
REQ-004 SW  in  18  SW[WIDTH-1:0] SHALL be minuend A; SW[WIDTH+7:8] SHALL be subtrahend B; all other bits SHALL be unused.
REQ-005 LEDR  out  8  LEDR[WIDTH-1:0] SHALL be registered difference D = A - B mod 2^WIDTH; upper bits SHALL be 0.
REQ-006 LEDG  out  4  [0] borrow out, [1] busy, [2] done, [3] signed overflow.

Function
REQ-007 KEY[1] SHALL pass through a 2-flop synchronizer; a 1-cycle start pulse SHALL assert on the first cycle the synchronized value is 0 after having been 1.
REQ-008 FSM states SHALL be IDLE, SHIFT and DONE; encoding is free.
REQ-009 IDLE or DONE with start pulse: capture A, B into shift registers; clear borrow flop to 0; clear bit counter to 0; go to SHIFT.
REQ-010 SHIFT, each cycle, using LSBs a, b and borrow bin:
- d = a^b^bin
- bout = (~a&b) | (~(a^b)&bin)
- shift A, B right by one
- shift d into the result register at bit WIDTH-1
- borrow <= bout
- counter++
REQ-011 SHIFT SHALL last exactly WIDTH cycles; on the WIDTH-th cycle the FSM SHALL go to DONE, and LEDR, LEDG[0] and LEDG[3] SHALL load on that same edge.
REQ-012 LEDG[3] SHALL be 1 iff A[WIDTH-1] != B[WIDTH-1] and D[WIDTH-1] != A[WIDTH-1], using the captured operands.
REQ-013 LEDG[1] SHALL be 1 exactly while in SHIFT; LEDG[2] SHALL be 1 exactly while in DONE.
REQ-014 Latency: counting the edge that first samples KEY[1]=0 as edge 1, capture SHALL occur on edge 3 and LEDG[2] SHALL rise on edge WIDTH+3.
REQ-015 Start pulses while in SHIFT SHALL be ignored; the operation SHALL not restart or extend.
REQ-016 SW changes after the capture edge SHALL not affect the operation in progress.
REQ-017 LEDR, LEDG[0] and LEDG[3] SHALL hold their last result through a subsequent SHIFT and update only on its completion edge.
REQ-018 DONE SHALL persist until the next start pulse or reset; holding KEY[1] low SHALL produce only one start.
REQ-019 A = B SHALL give D = 0, borrow 0, overflow 0; A < B unsigned SHALL give borrow 1.

Reset
REQ-020 KEY[0]=0 sampled on a rising edge SHALL force, on that edge:
- state IDLE
- LEDR = 0
- LEDG = 0
- counter = 0
- borrow = 0
- synchronizer flops = 1 (idle)
REQ-021 Reset SHALL override everything, including mid-SHIFT; a partial result SHALL never reach LEDR.
REQ-022 After reset deasserts, a KEY[1] held low throughout reset SHALL not generate a start until it is released and pressed again.
REQ-023 Without a clock edge, KEY[0] SHALL have no effect (synchronous reset).

Verification
REQ-024 WIDTH=8, A=0x05, B=0x03, press KEY[1] -> LEDR=0x02, LEDG[0]=0, LEDG[3]=0; LEDG[2] rises on edge 11; LEDG[1] high exactly 8 cycles.
REQ-025 A=0x03, B=0x05 -> LEDR=0xFE, LEDG[0]=1, LEDG[3]=0; A=0x00, B=0x00 -> LEDR=0x00, LEDG[0]=0, LEDG[3]=0.
REQ-026 A=0x80, B=0x01 -> LEDR=0x7F, LEDG[0]=0, LEDG[3]=1; A=0x7F, B=0xFF -> LEDR=0x80, LEDG[0]=1, LEDG[3]=1.
REQ-027 Start 0x05-0x03, then during SHIFT re-press KEY[1] and change SW to A=0x10, B=0x01 -> single completion with LEDR=0x02; the next press yields 0x0F.
REQ-028 Assert KEY[0]=0 on the 4th SHIFT cycle -> on the next edge LEDG=0, LEDR=0, IDLE; a fresh press of 0x09-0x04 yields LEDR=0x05.
REQ-029 Hold KEY[1] low for 100 cycles -> exactly one operation; DONE holds; release and re-press -> a second operation completes.
